// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes for load-use, branch, memory wait and halt.
// Optional memory-wait timeout (ERR state, memErr) is built when PIPE_CTRL_TIMEOUT_EN is defined.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ifidOP1,
    input  logic [3:0]  ifidOP2,
    input  logic        ifidUse1,
    input  logic        ifidUse2,
    input  logic        idexR,
    input  logic [3:0]  idexOP1,
    input  logic        branchTaken,
    input  logic        exmemR,
    input  logic        exmemW,
    input  logic        memReady,
    input  logic        memwbHalt,
    output logic        pcEn,
    output logic        ifidEn,
    output logic        idexEn,
    output logic        exmemEn,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        memwbFlush,
    output logic        memReq,
    output logic        memErr,
    output logic [1:0]  state,
    output logic [15:0] stallCnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALTED   = 2'd2,
        S_ERR      = 2'd3
    } state_t;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_stall_cnt;
    logic [7:0]  r_wait_cnt;

    logic w_req, w_mem_busy, w_load_use, w_timeout;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en;
    logic w_ifid_flush, w_idex_flush, w_memwb_flush, w_mem_req;

    assign w_req      = exmemR | exmemW;
    assign w_mem_busy = w_req & ~memReady;
    // Both source fields compare against the single ID/EX destination; r0 is an ordinary register.
    assign w_load_use = idexR & ((ifidUse1 & (ifidOP1 == idexOP1)) |
                                 (ifidUse2 & (ifidOP2 == idexOP1)));
    assign w_timeout  = TIMEOUT_EN & (r_wait_cnt == TIMEOUT_LAST) & ~memReady;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next        = r_state;
        w_pc_en       = 1'b0;
        w_ifid_en     = 1'b0;
        w_idex_en     = 1'b0;
        w_exmem_en    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_memwb_flush = 1'b0;
        w_mem_req     = 1'b0;
        unique case (r_state)
            S_RUN: begin
                w_mem_req = w_req;
                if (w_mem_busy) begin
                    w_next = S_MEM_WAIT;
                end else if (branchTaken) begin
                    {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b1111;
                    w_ifid_flush = 1'b1;
                    w_idex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_idex_en    = 1'b1;
                    w_exmem_en   = 1'b1;
                    w_idex_flush = 1'b1;
                end else begin
                    {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b1111;
                end
                // Halt only steers the next state; this cycle still decodes as a normal RUN cycle.
                if (memwbHalt) w_next = S_HALTED;
            end
            S_MEM_WAIT: begin
                w_mem_req = w_req;
                if (memReady) begin
                    {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en} = 4'b1111;
                    w_next = S_RUN;
                end else begin
                    w_memwb_flush = 1'b1;
                    if (w_timeout) w_next = S_ERR;
                end
            end
            S_HALTED: ;
            S_ERR:    ;
            default:  w_next = S_RUN;
        endcase
    end

    // Reset gates the decode directly so memReq drops the instant reset asserts.
    assign pcEn       = reset & w_pc_en;
    assign ifidEn     = reset & w_ifid_en;
    assign idexEn     = reset & w_idex_en;
    assign exmemEn    = reset & w_exmem_en;
    assign ifidFlush  = reset & w_ifid_flush;
    assign idexFlush  = reset & w_idex_flush;
    assign memwbFlush = reset & w_memwb_flush;
    assign memReq     = reset & w_mem_req;
    assign memErr     = reset & TIMEOUT_EN & (r_state == S_ERR);
    assign state      = r_state;
    assign stallCnt   = r_stall_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_stall_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (!w_pc_en) r_stall_cnt <= r_stall_cnt + 16'd1;
            if (r_state == S_MEM_WAIT) begin
                if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven per-cycle vectors through a scoreboard queue,
// plus hand-written reset-in-wait and (timeout build) timeout sequences.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ifidOP1, ifidOP2, idexOP1;
    logic        ifidUse1, ifidUse2, idexR, branchTaken;
    logic        exmemR, exmemW, memReady, memwbHalt;
    logic        pcEn, ifidEn, idexEn, exmemEn;
    logic        ifidFlush, idexFlush, memwbFlush, memReq, memErr;
    logic [1:0]  state;
    logic [15:0] stallCnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .ifidOP1(ifidOP1), .ifidOP2(ifidOP2), .ifidUse1(ifidUse1), .ifidUse2(ifidUse2),
        .idexR(idexR), .idexOP1(idexOP1), .branchTaken(branchTaken),
        .exmemR(exmemR), .exmemW(exmemW), .memReady(memReady), .memwbHalt(memwbHalt),
        .pcEn(pcEn), .ifidEn(ifidEn), .idexEn(idexEn), .exmemEn(exmemEn),
        .ifidFlush(ifidFlush), .idexFlush(idexFlush), .memwbFlush(memwbFlush),
        .memReq(memReq), .memErr(memErr), .state(state), .stallCnt(stallCnt)
    );

    typedef struct {
        logic [3:0] op1, op2;
        logic       use1, use2, ld;
        logic [3:0] ld_rd;
        logic       br, rd, wr, rdy, halt;
        logic [3:0] en;   // {pc, ifid, idex, exmem}
        logic [2:0] fl;   // {ifid, idex, memwb}
        logic       req;
        logic [1:0] st;
        logic       err;
    } vec_t;

    typedef struct packed {
        logic [3:0]  en;
        logic [2:0]  fl;
        logic        req;
        logic [1:0]  st;
        logic        err;
        logic [15:0] stall;
    } exp_t;

    localparam logic B0 = 1'b0;
    localparam logic B1 = 1'b1;

    exp_t        sb[$];
    logic [15:0] exp_stall;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op1, input logic [3:0] op2,
                                input logic u1, input logic u2, input logic ld,
                                input logic [3:0] ld_rd, input logic br, input logic rd,
                                input logic wr, input logic rdy, input logic halt,
                                input logic [3:0] en, input logic [2:0] fl, input logic req,
                                input logic [1:0] st, input logic err);
        vec_t v;
        v.op1 = op1; v.op2 = op2; v.use1 = u1; v.use2 = u2; v.ld = ld; v.ld_rd = ld_rd;
        v.br = br; v.rd = rd; v.wr = wr; v.rdy = rdy; v.halt = halt;
        v.en = en; v.fl = fl; v.req = req; v.st = st; v.err = err;
        return v;
    endfunction

    task automatic drive_idle();
        ifidOP1 = 4'd0; ifidOP2 = 4'd0; ifidUse1 = 1'b0; ifidUse2 = 1'b0;
        idexR = 1'b0; idexOP1 = 4'd0; branchTaken = 1'b0;
        exmemR = 1'b0; exmemW = 1'b0; memReady = 1'b0; memwbHalt = 1'b0;
    endtask

    // One cycle: drive after the rising edge, queue the expectation, compare on the falling edge.
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        ifidOP1 = v.op1; ifidOP2 = v.op2; ifidUse1 = v.use1; ifidUse2 = v.use2;
        idexR = v.ld; idexOP1 = v.ld_rd; branchTaken = v.br;
        exmemR = v.rd; exmemW = v.wr; memReady = v.rdy; memwbHalt = v.halt;
        sb.push_back({v.en, v.fl, v.req, v.st, v.err, exp_stall});
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "_en"},    32'({pcEn, ifidEn, idexEn, exmemEn}),     32'(e.en));
        check({tag, "_flush"}, 32'({ifidFlush, idexFlush, memwbFlush}), 32'(e.fl));
        check({tag, "_req"},   32'(memReq),   32'(e.req));
        check({tag, "_state"}, 32'(state),    32'(e.st));
        check({tag, "_err"},   32'(memErr),   32'(e.err));
        check({tag, "_stall"}, 32'(stallCnt), 32'(e.stall));
        if (!e.en[3]) exp_stall = exp_stall + 16'd1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive_idle();
        exmemR = 1'b1;
        branchTaken = 1'b1;
        reset = 1'b0;
        #1;
        check("rst_outputs", 32'({pcEn, ifidEn, idexEn, exmemEn, ifidFlush, idexFlush, memwbFlush, memReq}), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_stall", 32'(stallCnt), 32'd0);
        check("rst_err",   32'(memErr), 32'd0);
        drive_idle();
        reset = 1'b1;
        exp_stall = 16'd0;
        sb.delete();
    endtask

    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        //           op1   op2   u1 u2 ld rd    br rd wr rdy halt   en       fl      req st    err
        tbl[0]  = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B0,B0,B0,B0,B0, 4'b1111, 3'b000, B0, 2'd0, B0); // idle
        tbl[1]  = mk(4'd0, 4'd3, B0,B1,B1,4'd3, B0,B0,B0,B0,B0, 4'b0011, 3'b010, B0, 2'd0, B0); // load-use on op2
        tbl[2]  = mk(4'd0, 4'd3, B0,B1,B0,4'd3, B0,B0,B0,B0,B0, 4'b1111, 3'b000, B0, 2'd0, B0); // load moved on
        tbl[3]  = mk(4'd0, 4'd7, B1,B0,B1,4'd0, B0,B0,B0,B0,B0, 4'b0011, 3'b010, B0, 2'd0, B0); // r0 on op1
        tbl[4]  = mk(4'd5, 4'd5, B0,B0,B1,4'd5, B0,B0,B0,B0,B0, 4'b1111, 3'b000, B0, 2'd0, B0); // match, not read
        tbl[5]  = mk(4'd9, 4'd2, B1,B0,B1,4'd9, B1,B0,B0,B0,B0, 4'b1111, 3'b110, B0, 2'd0, B0); // branch beats load-use
        tbl[6]  = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B1,B0,B0,B0,B0, 4'b1111, 3'b110, B0, 2'd0, B0); // branch
        tbl[7]  = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B0,B1,B0,B1,B0, 4'b1111, 3'b000, B1, 2'd0, B0); // zero-latency read
        tbl[8]  = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B0,B1,B0,B0,B0, 4'b0000, 3'b000, B1, 2'd0, B0); // read busy
        tbl[9]  = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B0,B1,B0,B0,B0, 4'b0000, 3'b001, B1, 2'd1, B0); // wait 1
        tbl[10] = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B0,B1,B0,B0,B0, 4'b0000, 3'b001, B1, 2'd1, B0); // wait 2
        tbl[11] = mk(4'd4, 4'd0, B1,B0,B1,4'd4, B1,B1,B0,B1,B0, 4'b1111, 3'b000, B1, 2'd1, B0); // ready, hazards ignored
        tbl[12] = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B1,B0,B0,B0,B0, 4'b1111, 3'b110, B0, 2'd0, B0); // branch seen in RUN
        tbl[13] = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B0,B0,B0,B1,B0, 4'b1111, 3'b000, B0, 2'd0, B0); // stray memReady
        tbl[14] = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B0,B0,B0,B0,B1, 4'b1111, 3'b000, B0, 2'd0, B0); // halt in MEM/WB
        tbl[15] = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B0,B1,B0,B0,B0, 4'b0000, 3'b000, B0, 2'd2, B0); // halted, read
        tbl[16] = mk(4'd1, 4'd0, B1,B0,B1,4'd1, B1,B0,B0,B0,B0, 4'b0000, 3'b000, B0, 2'd2, B0); // halted, hazards
        tbl[17] = mk(4'd0, 4'd0, B0,B0,B0,4'd0, B0,B0,B0,B0,B0, 4'b0000, 3'b000, B0, 2'd2, B0); // halted, idle

        drive_idle();
        reset = 1'b0;
        exp_stall = 16'd0;
        do_reset();

        for (int i = 0; i < 18; i++) apply($sformatf("v%0d", i), tbl[i]);

        // Reset asserted in the second MEM_WAIT cycle aborts the access at once.
        do_reset();
        apply("rw_run", mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B1,B0,B0,B0, 4'b0000,3'b000,B1,2'd0,B0));
        apply("rw_w1",  mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B1,B0,B0,B0, 4'b0000,3'b001,B1,2'd1,B0));
        apply("rw_w2",  mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B1,B0,B0,B0, 4'b0000,3'b001,B1,2'd1,B0));
        #1 reset = 1'b0;
        #1;
        check("rw_req_async",   32'(memReq), 32'd0);
        check("rw_state_async", 32'(state), 32'd0);
        check("rw_flush_async", 32'(memwbFlush), 32'd0);
        @(posedge clk); #2;
        drive_idle();
        reset = 1'b1;
        exp_stall = 16'd0;
        check("rw_rel_state", 32'(state), 32'd0);
        check("rw_rel_stall", 32'(stallCnt), 32'd0);
        check("rw_rel_err",   32'(memErr), 32'd0);
        apply("rw_after", mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B1,B0,B1,B0, 4'b1111,3'b000,B1,2'd0,B0));

`ifdef PIPE_CTRL_TIMEOUT_EN
        // Write never completes: four wait cycles, then ERR.
        do_reset();
        apply("to_run", mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B0,B1,B0,B0, 4'b0000,3'b000,B1,2'd0,B0));
        for (int k = 1; k <= 4; k++)
            apply($sformatf("to_w%0d", k), mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B0,B1,B0,B0, 4'b0000,3'b001,B1,2'd1,B0));
        apply("to_err1", mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B0,B1,B0,B0, 4'b0000,3'b000,B0,2'd3,B1));
        apply("to_err2", mk(4'd0,4'd0,B0,B0,B0,4'd0,B1,B0,B1,B1,B0, 4'b0000,3'b000,B0,2'd3,B1));

        // Ready in the fourth wait cycle wins over the timeout.
        do_reset();
        apply("tr_run", mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B0,B1,B0,B0, 4'b0000,3'b000,B1,2'd0,B0));
        for (int k = 1; k <= 3; k++)
            apply($sformatf("tr_w%0d", k), mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B0,B1,B0,B0, 4'b0000,3'b001,B1,2'd1,B0));
        apply("tr_w4",  mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B0,B1,B1,B0, 4'b1111,3'b000,B1,2'd1,B0));
        apply("tr_run2", mk(4'd0,4'd0,B0,B0,B0,4'd0,B0,B0,B0,B0,B0, 4'b1111,3'b000,B0,2'd0,B0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
